// File: rtl/x74161_chain.sv
// x74161_chain: cascade of 74161-style 4-bit counters with async clear, sync load,
// ENP/ENT enables, per-stage ripple carry and a registered terminal-count pulse.
module x74161_chain #(
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load_n,
    input  logic                  enp,
    input  logic                  ent,
    input  logic [4*STAGES-1:0]   d,
    output logic [4*STAGES-1:0]   q,
    output logic [STAGES-1:0]     rco,
    output logic                  tc,
    output logic                  tc_q
);
    logic [STAGES-1:0] ent_s;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [3:0] cnt;
        if (i == 0) begin : g_first
            assign ent_s[i] = ent;
        end else begin : g_next
            assign ent_s[i] = rco[i-1];
        end
        // rco ignores enp/load_n, matching the discrete part
        assign rco[i] = ent_s[i] & (cnt == 4'hF);
        assign q[4*i +: 4] = cnt;
        always_ff @(posedge clk or negedge clr)
            if (!clr) cnt <= 4'h0;
            else if (!load_n) cnt <= d[4*i +: 4];
            else if (enp && ent_s[i]) cnt <= cnt + 4'h1;
    end
    assign tc = rco[STAGES-1];
    always_ff @(posedge clk or negedge clr)
        if (!clr) tc_q <= 1'b0;
        else tc_q <= tc;
endmodule

// File: tb/tb_x74161_chain.sv
// tb_x74161_chain: directed-vector bench for the STAGES=2 counter chain.
`timescale 1ns/1ps
module tb_x74161_chain;
    logic       clk = 1'b0;
    logic       clr, load_n, enp, ent;
    logic [7:0] d;
    logic [7:0] q;
    logic [1:0] rco;
    logic       tc, tc_q;
    int         n_run = 0;
    int         n_fail = 0;

    x74161_chain #(.STAGES(2)) dut (
        .clk(clk), .clr(clr), .load_n(load_n), .enp(enp), .ent(ent),
        .d(d), .q(q), .rco(rco), .tc(tc), .tc_q(tc_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 8'h00;
        #3;
        chk("rst_q", q, 8'h00);
        chk("rst_tcq", {7'b0, tc_q}, 8'h00);
        chk("rst_rco", {6'b0, rco}, 8'h00);
        #4 clr = 1'b1;
        // clear between edges
        load_n = 1'b0; d = 8'h5A;
        step();
        chk("ld5a", q, 8'h5A);
        load_n = 1'b1;
        #2 clr = 1'b0;
        #1;
        chk("clr_q", q, 8'h00);
        chk("clr_tcq", {7'b0, tc_q}, 8'h00);
        repeat (3) begin
            step();
            chk("clr_hold_q", q, 8'h00);
            chk("clr_hold_tcq", {7'b0, tc_q}, 8'h00);
        end
        clr = 1'b1;
        // load then count through wrap
        load_n = 1'b0; d = 8'hFD;
        step();
        chk("ldfd", q, 8'hFD);
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        step();
        chk("cnt_fe", q, 8'hFE);
        chk("tc_fe", {7'b0, tc}, 8'h00);
        step();
        chk("cnt_ff", q, 8'hFF);
        chk("rco_ff", {6'b0, rco}, 8'h03);
        chk("tc_ff", {7'b0, tc}, 8'h01);
        step();
        chk("wrap_q", q, 8'h00);
        chk("wrap_tc", {7'b0, tc}, 8'h00);
        chk("wrap_tcq", {7'b0, tc_q}, 8'h01);
        step();
        chk("cnt_01", q, 8'h01);
        chk("tcq_01", {7'b0, tc_q}, 8'h00);
        // inter-stage carry
        load_n = 1'b0; d = 8'h0F;
        step();
        chk("ld0f", q, 8'h0F);
        load_n = 1'b1;
        #1;
        chk("rco_0f", {6'b0, rco}, 8'h01);
        step();
        chk("carry_q", q, 8'h10);
        chk("carry_rco", {6'b0, rco}, 8'h00);
        // enable gating
        load_n = 1'b0; d = 8'hFF;
        step();
        chk("ldff", q, 8'hFF);
        chk("ldff_tcq", {7'b0, tc_q}, 8'h00);
        load_n = 1'b1; enp = 1'b0;
        #1;
        chk("gate_tc", {7'b0, tc}, 8'h01);
        step();
        chk("gate_tcq", {7'b0, tc_q}, 8'h01);
        repeat (4) begin
            chk("gate_hold", q, 8'hFF);
            step();
        end
        ent = 1'b0;
        #1;
        chk("gate_rco0", {6'b0, rco}, 8'h00);
        chk("gate_tc0", {7'b0, tc}, 8'h00);
        chk("gate_q", q, 8'hFF);
        // load beats terminal count
        ent = 1'b1; enp = 1'b1; load_n = 1'b0; d = 8'h30;
        step();
        chk("ldpri_q", q, 8'h30);
        chk("ldpri_tcq", {7'b0, tc_q}, 8'h01);
        // clear beats load
        d = 8'hAA; clr = 1'b0;
        step();
        chk("clrpri_q", q, 8'h00);
        #3 clr = 1'b1;
        step();
        chk("clrrel_ld", q, 8'hAA);
        // reset mid-count, resume from zero
        load_n = 1'b1;
        step();
        chk("cnt_ab", q, 8'hAB);
        #2 clr = 1'b0;
        #1 clr = 1'b1;
        chk("mid_clr", q, 8'h00);
        step();
        chk("resume", q, 8'h01);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
